// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: one byte per valid/ready handshake, full request-to-send sequence.
// Optional build macro PS2_TX_RETRY_EN retries a NACKed or timed-out byte up to two more times.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter int DATA_WIDTH     = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  tx_done,
   output logic                  tx_error,
   input  logic                  ps2_clk_in,
   input  logic                  ps2_data_in,
   output logic                  ps2_clk_oe,
   output logic                  ps2_data_oe
);

   localparam int FRAME_W = DATA_WIDTH + 2;
   localparam int BIT_W   = $clog2(FRAME_W + 1);
   localparam int INH_W   = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [INH_W-1:0] INH_DATA = INH_W'(INHIBIT_CYCLES - 2);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BIT_W-1:0] BIT_STOP = BIT_W'(FRAME_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQ       = 3'd2,
      ST_SEND      = 3'd3,
      ST_ACK       = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } state_t;

   // Frame transmitted LSB first after the start bit: data, odd parity, stop.
   function automatic logic [FRAME_W-1:0] build_frame(input logic [DATA_WIDTH-1:0] d);
      return {1'b1, ~^d, d};
   endfunction

   state_t                state_q;
   logic [DATA_WIDTH-1:0] byte_q;
   logic [FRAME_W-1:0]    shift_q;
   logic [BIT_W-1:0]      bit_cnt_q;
   logic [INH_W-1:0]      inh_cnt_q;
   logic [TO_W-1:0]       to_cnt_q;
   logic                  clk_s1_q, clk_s2_q, clk_prev_q;
   logic                  data_s1_q, data_s2_q;
   logic                  tx_ready_q, tx_done_q, tx_error_q;
   logic                  clk_oe_q, data_oe_q;

   logic                  fe_s;
   logic                  timed_s;
   logic                  accept_s;
   logic                  fail_s;
   logic                  retry_left_s;

   // Pin synchronizers; idle-high reset value avoids a false edge after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         data_s1_q  <= 1'b1;
         data_s2_q  <= 1'b1;
      end else begin
         clk_s1_q   <= ps2_clk_in;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         data_s1_q  <= ps2_data_in;
         data_s2_q  <= data_s1_q;
      end
   end

   assign fe_s     = clk_prev_q & ~clk_s2_q;
   assign timed_s  = (state_q == ST_REQ) || (state_q == ST_SEND) ||
                     (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
   assign accept_s = tx_valid & tx_ready_q;
   // Timeout outranks any edge seen in the same cycle.
   assign fail_s   = (timed_s && (to_cnt_q == TO_LAST)) ||
                     ((state_q == ST_ACK) && fe_s && data_s2_q);

`ifdef PS2_TX_RETRY_EN
   logic [1:0] retry_q;

   assign retry_left_s = (retry_q != 2'd2);

   // Failed-attempt count for the byte in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retry_q <= 2'd0;
      end else if (accept_s) begin
         retry_q <= 2'd0;
      end else if (fail_s && retry_left_s) begin
         retry_q <= retry_q + 2'd1;
      end else begin
         retry_q <= retry_q;
      end
   end
`else
   assign retry_left_s = 1'b0;
`endif

   // Transmit sequencer with registered handshake and line-drive outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         byte_q     <= '0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         inh_cnt_q  <= '0;
         to_cnt_q   <= '0;
         tx_ready_q <= 1'b1;
         tx_done_q  <= 1'b0;
         tx_error_q <= 1'b0;
         clk_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
      end else begin
         tx_done_q  <= 1'b0;
         tx_error_q <= 1'b0;
         if (fail_s) begin
            data_oe_q <= 1'b0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            if (retry_left_s) begin
               clk_oe_q <= 1'b1;
               state_q  <= ST_INHIBIT;
            end else begin
               clk_oe_q   <= 1'b0;
               tx_error_q <= 1'b1;
               state_q    <= ST_IDLE;
            end
         end else begin
            case (state_q)
               ST_IDLE: begin
                  clk_oe_q  <= 1'b0;
                  data_oe_q <= 1'b0;
                  if (accept_s) begin
                     byte_q     <= tx_data;
                     bit_cnt_q  <= '0;
                     inh_cnt_q  <= '0;
                     to_cnt_q   <= '0;
                     tx_ready_q <= 1'b0;
                     clk_oe_q   <= 1'b1;
                     state_q    <= ST_INHIBIT;
                  end else begin
                     tx_ready_q <= 1'b1;
                  end
               end
               ST_INHIBIT: begin
                  inh_cnt_q <= inh_cnt_q + INH_W'(1);
                  if (inh_cnt_q == INH_DATA) begin
                     data_oe_q <= 1'b1;
                  end
                  if (inh_cnt_q == INH_LAST) begin
                     clk_oe_q  <= 1'b0;
                     data_oe_q <= 1'b1;
                     shift_q   <= build_frame(byte_q);
                     to_cnt_q  <= '0;
                     state_q   <= ST_REQ;
                  end
               end
               ST_REQ: begin
                  to_cnt_q <= to_cnt_q + TO_W'(1);
                  if (fe_s) begin
                     data_oe_q <= ~shift_q[0];
                     shift_q   <= {1'b1, shift_q[FRAME_W-1:1]};
                     bit_cnt_q <= BIT_W'(1);
                     state_q   <= ST_SEND;
                  end
               end
               ST_SEND: begin
                  to_cnt_q <= to_cnt_q + TO_W'(1);
                  if (fe_s) begin
                     data_oe_q <= ~shift_q[0];
                     shift_q   <= {1'b1, shift_q[FRAME_W-1:1]};
                     bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                     if (bit_cnt_q == BIT_STOP) begin
                        state_q <= ST_ACK;
                     end
                  end
               end
               ST_ACK: begin
                  to_cnt_q <= to_cnt_q + TO_W'(1);
                  if (fe_s) begin
                     state_q <= ST_WAIT_IDLE;
                  end
               end
               ST_WAIT_IDLE: begin
                  to_cnt_q <= to_cnt_q + TO_W'(1);
                  if (clk_s2_q && data_s2_q) begin
                     tx_done_q <= 1'b1;
                     to_cnt_q  <= '0;
                     state_q   <= ST_IDLE;
                  end
               end
               default: begin
                  clk_oe_q  <= 1'b0;
                  data_oe_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign tx_ready    = tx_ready_q;
   assign tx_done     = tx_done_q;
   assign tx_error    = tx_error_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain line model and a behavioural PS/2 device.
module tb_ps2_host_tx;

   localparam int INH  = 10;
   localparam int TO   = 4000;
   localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
   localparam int ATTEMPTS = 3;
   localparam int TO_TOTAL = TO + 2 * (TO + INH);
`else
   localparam int ATTEMPTS = 1;
   localparam int TO_TOTAL = TO;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, tx_done, tx_error;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       ps2_clk_in, ps2_data_in;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;

   int n_assert = 0;
   int n_fail   = 0;
   int acc_cnt  = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int exp_acc  = 0;

   always #5 clk = ~clk;

   assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .DATA_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error),
      .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
   );

   always @(posedge clk) begin
      if (rst_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) acc_cnt <= acc_cnt + 1;
   end

   always @(negedge clk) begin
      if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
      if (tx_error === 1'b1) err_cnt <= err_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference frame: data LSB first, odd parity, stop bit.
   function automatic logic [9:0] model_frame(input logic [7:0] b);
      int ones = 0;
      logic [9:0] f;
      for (int i = 0; i < 8; i++) begin
         f[i] = b[i];
         ones += int'(b[i]);
      end
      f[8] = ((ones % 2) == 0);
      f[9] = 1'b1;
      return f;
   endfunction

   task automatic accept_byte(input logic [7:0] b, input bit hold, input logic [7:0] nxt);
      int   t = 0;
      int   cnt = 0;
      int   dcnt = 0;
      logic last_d = 1'b0;
      exp_acc++;
      tx_data  = b;
      tx_valid = 1'b1;
      while (acc_cnt < exp_acc && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("accept", acc_cnt >= exp_acc, 1);
      if (hold) begin
         tx_data = nxt;
      end else begin
         tx_valid = 1'b0;
         tx_data  = 8'($urandom);
      end
      chk("ready_drop", tx_ready, 0);
      t = 0;
      while (ps2_clk_oe === 1'b1 && t < 200) begin
         cnt++;
         if (ps2_data_oe === 1'b1) dcnt++;
         last_d = ps2_data_oe;
         @(negedge clk);
         t++;
      end
      chk("inhibit_len", cnt, INH);
      chk("inhibit_data_cycles", dcnt, 1);
      chk("inhibit_data_last", last_d, 1);
      chk("req_data_oe", ps2_data_oe, 1);
      chk("req_clk_oe", ps2_clk_oe, 0);
   endtask

   task automatic dev_frame(input int nbits, input bit ack, output logic [9:0] bits);
      int t = 0;
      bits = '0;
      while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("dev_start_bit", t < 500, 1);
      repeat (10) @(posedge clk);
      for (int k = 0; k < nbits; k++) begin
         #1 dev_clk = 1'b0;
         repeat (HALF - 1) @(posedge clk);
         @(negedge clk);
         bits[k] = ps2_data_in;
         @(posedge clk);
         #1 dev_clk = 1'b1;
         repeat (HALF) @(posedge clk);
      end
      if (nbits == 10) begin
         #1 if (ack) dev_data = 1'b0;
         repeat (5) @(posedge clk);
         #1 dev_clk = 1'b0;
         repeat (HALF) @(posedge clk);
         #1 dev_clk = 1'b1;
         repeat (5) @(posedge clk);
         #1 dev_data = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit ack, input bit hold, input logic [7:0] nxt);
      logic [9:0] bits;
      logic [9:0] exp;
      int d0, e0, t, attempts;
      d0 = done_cnt;
      e0 = err_cnt;
      exp = model_frame(b);
      attempts = ack ? 1 : ATTEMPTS;
      accept_byte(b, hold, nxt);
      for (int a = 0; a < attempts; a++) begin
         dev_frame(10, ack, bits);
         for (int k = 0; k < 10; k++) chk($sformatf("frame_%02h_bit%0d", b, k), bits[k], exp[k]);
         if (a < attempts - 1) chk("no_early_error", err_cnt - e0, 0);
      end
      if (ack) begin
         t = 0;
         while (tx_done !== 1'b1 && tx_error !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
         end
         chk("done_pulse", tx_done, 1);
         chk("no_error_with_done", tx_error, 0);
         chk("ready_low_in_pulse", tx_ready, 0);
         chk("single_accept", acc_cnt, exp_acc);
         @(negedge clk);
         chk("done_one_cycle", tx_done, 0);
         chk("ready_back", tx_ready, 1);
         chk("oe_idle", {ps2_clk_oe, ps2_data_oe}, 0);
         chk("done_count", done_cnt - d0, 1);
         chk("error_count", err_cnt - e0, 0);
         chk("single_accept_after", acc_cnt, exp_acc);
      end else begin
         repeat (5) @(negedge clk);
         chk("nack_error_count", err_cnt - e0, 1);
         chk("nack_no_done", done_cnt - d0, 0);
         chk("nack_oe_idle", {ps2_clk_oe, ps2_data_oe}, 0);
         chk("nack_ready", tx_ready, 1);
      end
   endtask

   initial begin
      logic [9:0] bits;
      logic [9:0] exp;
      logic       prev_d;
      int         c, d0, e0, a0;

      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_ready", tx_ready, 1);
      chk("reset_done", tx_done, 0);
      chk("reset_error", tx_error, 0);
      chk("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      send_frame(8'hED, 1'b1, 1'b0, 8'h00);

      send_frame(8'h01, 1'b1, 1'b1, 8'hFF);
      send_frame(8'hFF, 1'b1, 1'b0, 8'h00);

      send_frame(8'hF4, 1'b0, 1'b0, 8'h00);

      d0 = done_cnt;
      e0 = err_cnt;
      accept_byte(8'hAA, 1'b0, 8'h00);
      c = 0;
      prev_d = ps2_data_oe;
      while (tx_error !== 1'b1 && c < TO_TOTAL + 100) begin
         prev_d = ps2_data_oe;
         @(negedge clk);
         c++;
      end
      chk("timeout_cycles", c, TO_TOTAL);
      chk("timeout_prev_data_oe", prev_d, 1);
      chk("timeout_release", {ps2_clk_oe, ps2_data_oe}, 0);
      chk("timeout_no_done", tx_done, 0);
      @(negedge clk);
      chk("timeout_ready_back", tx_ready, 1);
      chk("timeout_error_count", err_cnt - e0, 1);
      chk("timeout_done_count", done_cnt - d0, 0);

      accept_byte(8'h55, 1'b0, 8'h00);
      dev_frame(4, 1'b1, bits);
      exp = model_frame(8'h55);
      for (int k = 0; k < 4; k++) chk($sformatf("partial_bit%0d", k), bits[k], exp[k]);
      chk("pre_reset_data_oe", ps2_data_oe, 1);
      d0 = done_cnt;
      e0 = err_cnt;
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      chk("async_reset_ready", tx_ready, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_no_done", done_cnt - d0, 0);
      chk("reset_no_error", err_cnt - e0, 0);
      chk("post_reset_ready", tx_ready, 1);
      send_frame(8'h55, 1'b1, 1'b0, 8'h00);

      d0 = done_cnt;
      e0 = err_cnt;
      a0 = acc_cnt;
      for (int i = 0; i < 4; i++) begin
         dev_clk = 1'b0;
         repeat (10) @(negedge clk);
         chk("idle_toggle_oe_lo", {ps2_clk_oe, ps2_data_oe}, 0);
         chk("idle_toggle_ready_lo", tx_ready, 1);
         dev_clk = 1'b1;
         repeat (10) @(negedge clk);
         chk("idle_toggle_oe_hi", {ps2_clk_oe, ps2_data_oe}, 0);
      end
      chk("idle_toggle_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
      chk("idle_toggle_accepts", acc_cnt - a0, 0);

      for (int r = 0; r < 3; r++) send_frame(8'($urandom), 1'b1, 1'b0, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; the transmit direction of the PS/2 controller, alongside the existing device-to-host receive path.
- Accepts one command byte per valid/ready handshake and runs the full PS/2 host request-to-send sequence on the open-drain clock and data lines.
- Used for device commands, e.g. keyboard LED 0xED, reset 0xFF.

Parameters:
INHIBIT_CYCLES, 5000, system clocks ps2_clk is held low before request-to-send (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, max system clocks from clock release to ACK completion (15 ms at 50 MHz)
DATA_WIDTH, 8, payload width; fixed at 8 by protocol, parameterised for consistency only

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_WIDTH  byte to send, sampled on accept
tx_valid  input  1  request to send tx_data
tx_ready  output  1  high only in IDLE; accept = tx_valid & tx_ready on rising clk
tx_done  output  1  one-cycle pulse, byte sent and device ACKed
tx_error  output  1  one-cycle pulse, NACK or timeout
ps2_clk_in  input  1  raw PS/2 clock pin level (asynchronous)
ps2_data_in  input  1  raw PS/2 data pin level (asynchronous)
ps2_clk_oe  output  1  1 = drive PS/2 clock low, 0 = release
ps2_data_oe  output  1  1 = drive PS/2 data low, 0 = release

Behaviour:
- Reset (async, rst_n=0): state IDLE; ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_error=0, tx_ready=1; all counters 0. Both lines are released immediately when reset asserts, even mid-frame.
- Input sync: ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer. A falling edge (fe) is synced clk previous=1, current=0. fe is ignored in IDLE and INHIBIT.
- Frame bits: the shift register holds {stop=1, parity, data[7:0]}, sent LSB first. Parity is odd: parity = ~^tx_data.
- IDLE: tx_ready=1. On accept, latch the byte, clear counters, go to INHIBIT. tx_ready drops the next cycle.
- INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES cycles. ps2_data_oe=1 in the final cycle. Then go to REQ.
- REQ: ps2_clk_oe=0, ps2_data_oe=1 (start bit 0). Start the timeout counter. On the first fe, drive data bit 0 and go to SEND with bit_cnt=1.
- SEND:
  - On each fe, the cycle after detection: ps2_data_oe = ~next bit, and bit_cnt increments.
  - Order: data[1..7], then parity, then stop (ps2_data_oe=0).
  - After the fe that places the stop bit (bit_cnt=10), go to ACK.
- ACK:
  - On the next fe, sample synced data. 0 = ACK; 1 = NACK.
  - ACK: go to WAIT_IDLE.
  - NACK: pulse tx_error, go to IDLE.
- WAIT_IDLE: wait until synced clk=1 and synced data=1. Then pulse tx_done and go to IDLE.
- Timeout:
  - Counter runs in REQ, SEND, ACK and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES: release both lines the same cycle, pulse tx_error, go to IDLE.
  - Timeout takes priority over a simultaneous fe.
- tx_done and tx_error never assert in the same cycle. tx_ready reasserts the cycle after either pulse.
- tx_data changes after accept have no effect on the frame in flight.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - A NACK or timeout restarts from INHIBIT with the same latched byte, up to 2 retries (3 attempts total).
  - tx_error pulses only after the third failed attempt.
  - tx_ready stays low throughout the retries.
- Undefined: the first failure pulses tx_error and returns to IDLE. No retry counter is instantiated.

Test Plan:
Bench settings for all scenarios: INHIBIT_CYCLES=10, TIMEOUT_CYCLES=4000, device model clocking at 1/40 of clk.
- Send 0xED, device ACKs -> clk_oe high 10 cycles. Data bits on successive falls: 1,0,1,1,0,1,1,1, parity 1, stop 1. One tx_done pulse, tx_ready back to 1.
- Send 0x01, then 0xFF, back-to-back -> parity bits 0 and 1 respectively. Second accept occurs only after the first tx_done. Two tx_done pulses.
- Send 0xF4, device leaves data high at the ACK fall (NACK) -> tx_error pulse, no tx_done, both oe=0. With PS2_TX_RETRY_EN: three full frames, then one tx_error.
- Send 0xAA, device never clocks -> tx_error 4000 cycles after REQ entry; lines released the same cycle.
- Assert rst_n=0 after the 4th data bit of 0x55 -> clk_oe and data_oe drop to 0 asynchronously; no done or error pulse. After release, tx_ready=1 and a fresh 0x55 completes correctly.
- Toggle ps2_clk_in while IDLE with tx_valid=0 -> no state change; oe outputs stay 0.
